// File: rtl/mmu_filt_pkg.sv
// Shared types, default parameters and address-field width helpers for the mmu_filt block.
package mmu_filt_pkg;

  localparam int DEF_DW     = 24;
  localparam int DEF_NCH    = 2;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_NCOEF  = 8;
  localparam int DEF_FDEPTH = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } filt_st_t;

  function automatic int f_chw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int f_cw(input int ncoef);
    return $clog2(ncoef) + 1;
  endfunction

  // Width of the shared idx field: large enough for a bank index or a coefficient/counter index.
  function automatic int f_xw(input int depth, input int ncoef);
    return ($clog2(depth) > f_cw(ncoef)) ? $clog2(depth) : f_cw(ncoef);
  endfunction

  function automatic int f_aw(input int nch, input int depth, input int ncoef);
    return 1 + f_chw(nch) + f_xw(depth, ncoef);
  endfunction

endpackage

// File: rtl/mmu_filt_sync_fifo.sv
// First-word-fall-through FIFO; head visible combinationally, zero while empty.
// Pushes while full and pops while empty are dropped; full/empty reflect state before this cycle's pop.
module mmu_filt_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push     = i_push_vld & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_head_dat = o_empty ? '0 : r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/mmu_filt_mc.sv
// Per-channel ping-pong sample capture with CPU readback (1-cycle read latency) and a coefficient write FIFO;
// cpu_stall holds off coefficient writes while the FIFO is full. MMU_FILT_OVR_CNT_EN adds per-channel drop counters.
module mmu_filt_mc
  import mmu_filt_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NCH    = DEF_NCH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NCOEF  = DEF_NCOEF,
  parameter int FDEPTH = DEF_FDEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cpu_en,
  input  logic                                cpu_rw,
  input  logic [f_aw(NCH, DEPTH, NCOEF)-1:0]  cpu_addr,
  input  logic [DW-1:0]                       cpu_din,
  output logic [DW-1:0]                       cpu_dout,
  output logic                                cpu_stall,
  input  logic [NCH-1:0]                      filt_drdy,
  input  logic [NCH*DW-1:0]                   filt_data,
  output logic [NCH-1:0]                      filt_int,
  input  logic [NCH-1:0]                      int_ack,
  input  logic                                coef_rd_en,
  output logic                                coef_empty,
  output logic [f_chw(NCH)-1:0]               coef_ch,
  output logic [f_cw(NCOEF)-2:0]              coef_addr,
  output logic [DW-1:0]                       coef_data
);
  localparam int CHW = f_chw(NCH);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = f_cw(NCOEF);
  localparam int XW  = f_xw(DEPTH, NCOEF);
  localparam int AW  = 1 + CHW + XW;
  localparam int FW  = CHW + CW - 1 + DW;

  logic           w_region;
  logic [CHW-1:0] w_ch;
  logic [XW-1:0]  w_idx;
  logic           w_ch_ok;
  logic           w_idx_bank;
  logic           w_idx_coef;
  logic           w_idx_ovr;
  logic           w_coef_wr;
  logic           w_push;
  logic           w_full;
  logic [FW-1:0]  w_head;
  logic [DW-1:0]  w_rd_data;
  logic [DW-1:0]  r_cpu_dout;
  logic [DW-1:0]  w_bank_rd [NCH];
  logic [15:0]    w_ovr [NCH];
  logic [DW-1:0]  r_shadow [NCH][NCOEF];

  assign w_region   = cpu_addr[AW-1];
  assign w_ch       = cpu_addr[XW +: CHW];
  assign w_idx      = cpu_addr[XW-1:0];
  assign w_ch_ok    = {1'b0, w_ch} < (CHW+1)'(NCH);
  assign w_idx_bank = {1'b0, w_idx} < (XW+1)'(DEPTH);
  assign w_idx_coef = {1'b0, w_idx} < (XW+1)'(NCOEF);
  assign w_idx_ovr  = {1'b0, w_idx} == (XW+1)'(NCOEF);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    filt_st_t        r_st, w_st_nxt;
    logic [IW-1:0]   r_wptr, w_wptr_nxt;
    logic            r_wbank, w_wbank_nxt;
    logic            r_int, w_int_nxt;
    logic            w_wr;
    logic            w_last;
    logic [DW-1:0]   r_bank [2*DEPTH];

    assign w_last      = (r_wptr == IW'(DEPTH-1));
    assign filt_int[c] = r_int;

    always_comb begin
      w_st_nxt    = r_st;
      w_wptr_nxt  = r_wptr;
      w_wbank_nxt = r_wbank;
      w_int_nxt   = r_int;
      w_wr        = 1'b0;
      unique case (r_st)
        FILL: begin
          if (filt_drdy[c]) begin
            w_wr       = 1'b1;
            w_wptr_nxt = r_wptr + 1'b1;
            if (w_last) begin
              w_wbank_nxt = ~r_wbank;
              w_int_nxt   = 1'b1;
              w_st_nxt    = PEND;
            end
          end
        end
        PEND: begin
          if (filt_drdy[c]) begin
            w_wr       = 1'b1;
            w_wptr_nxt = r_wptr + 1'b1;
          end
          // A bank completing while unacknowledged parks in HOLD; a coincident ack frees the other bank instead.
          if (filt_drdy[c] && w_last) begin
            if (int_ack[c]) w_wbank_nxt = ~r_wbank;
            else            w_st_nxt    = HOLD;
          end else if (int_ack[c]) begin
            w_int_nxt = 1'b0;
            w_st_nxt  = FILL;
          end
        end
        HOLD: begin
          if (int_ack[c]) begin
            w_wbank_nxt = ~r_wbank;
            w_st_nxt    = PEND;
          end
        end
        default: w_st_nxt = FILL;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st    <= FILL;
        r_wptr  <= '0;
        r_wbank <= 1'b0;
        r_int   <= 1'b0;
      end else begin
        r_st    <= w_st_nxt;
        r_wptr  <= w_wptr_nxt;
        r_wbank <= w_wbank_nxt;
        r_int   <= w_int_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr) r_bank[{r_wbank, r_wptr}] <= filt_data[c*DW +: DW];
    end

    assign w_bank_rd[c] = r_bank[{~r_wbank, w_idx[IW-1:0]}];

`ifdef MMU_FILT_OVR_CNT_EN
    logic [15:0] r_ovr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_ovr <= '0;
      else if (int_ack[c] && r_st != FILL) r_ovr <= '0;
      else if (r_st == HOLD && filt_drdy[c] && r_ovr != '1) r_ovr <= r_ovr + 1'b1;
    end
    assign w_ovr[c] = r_ovr;
`else
    assign w_ovr[c] = '0;
`endif
  end

  always_comb begin
    w_rd_data = '0;
    if (w_ch_ok) begin
      if (!w_region) begin
        if (w_idx_bank) w_rd_data = w_bank_rd[w_ch];
      end else if (w_idx_coef) begin
        w_rd_data = r_shadow[w_ch][w_idx[CW-2:0]];
      end else if (w_idx_ovr) begin
        w_rd_data = DW'(w_ovr[w_ch]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_cpu_dout <= '0;
    else if (cpu_en & cpu_rw) r_cpu_dout <= w_rd_data;
  end
  assign cpu_dout = r_cpu_dout;

  assign w_coef_wr = cpu_en & ~cpu_rw & w_region & w_idx_coef & w_ch_ok;
  assign cpu_stall = w_coef_wr & w_full;
  assign w_push    = w_coef_wr & ~w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_shadow[w_ch][w_idx[CW-2:0]] <= cpu_din;
  end

  mmu_filt_sync_fifo #(
    .W     (FW),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (w_push),
    .i_push_dat ({w_ch, w_idx[CW-2:0], cpu_din}),
    .i_pop      (coef_rd_en),
    .o_head_dat (w_head),
    .o_empty    (coef_empty),
    .o_full     (w_full)
  );

  assign {coef_ch, coef_addr, coef_data} = w_head;

endmodule

// File: tb/tb_mmu_filt_mc.sv
// Directed bench for mmu_filt_mc at DW=24, NCH=2, DEPTH=8, NCOEF=8, FDEPTH=4.
module tb_mmu_filt_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_rw;
  logic [5:0]  cpu_addr;
  logic [23:0] cpu_din;
  logic [23:0] cpu_dout;
  logic        cpu_stall;
  logic [1:0]  filt_drdy;
  logic [47:0] filt_data;
  logic [1:0]  filt_int;
  logic [1:0]  int_ack;
  logic        coef_rd_en;
  logic        coef_empty;
  logic [0:0]  coef_ch;
  logic [2:0]  coef_addr;
  logic [23:0] coef_data;

  int n_pass = 0;
  int n_total = 0;

  mmu_filt_mc #(.DW(24), .NCH(2), .DEPTH(8), .NCOEF(8), .FDEPTH(4)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .filt_drdy(filt_drdy), .filt_data(filt_data), .filt_int(filt_int), .int_ack(int_ack),
    .coef_rd_en(coef_rd_en), .coef_empty(coef_empty), .coef_ch(coef_ch),
    .coef_addr(coef_addr), .coef_data(coef_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic smp(input int c, input logic [23:0] v, input logic ack);
    filt_data[c*24 +: 24] = v;
    filt_drdy[c] = 1'b1;
    int_ack[c] = ack;
    tick();
    filt_drdy = '0;
    int_ack = '0;
  endtask

  task automatic ack(input int c);
    int_ack[c] = 1'b1;
    tick();
    int_ack = '0;
  endtask

  task automatic rd(input string tag, input logic reg1, input logic ch, input logic [3:0] idx,
                    input logic [23:0] exp);
    cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = {reg1, ch, idx};
    tick();
    cpu_en = 1'b0;
    chk(tag, {8'h0, cpu_dout}, {8'h0, exp});
  endtask

  task automatic wr(input string tag, input logic reg1, input logic ch, input logic [3:0] idx,
                    input logic [23:0] d);
    cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = {reg1, ch, idx}; cpu_din = d;
    #1;
    chk({tag, "_nostall"}, {31'h0, cpu_stall}, 32'h0);
    tick();
    cpu_en = 1'b0;
  endtask

  task automatic head(input string tag, input logic ch, input logic [2:0] a, input logic [23:0] d);
    chk({tag, "_empty"}, {31'h0, coef_empty}, 32'h0);
    chk({tag, "_hd"}, {4'h0, coef_ch, coef_addr, coef_data}, {4'h0, ch, a, d});
  endtask

  task automatic pop();
    coef_rd_en = 1'b1;
    tick();
    coef_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_en = 0; cpu_rw = 0; cpu_addr = '0; cpu_din = '0;
    filt_drdy = '0; filt_data = '0; int_ack = '0; coef_rd_en = 0;
    tick(); tick();
    chk("rst_int", {30'h0, filt_int}, 32'h0);
    chk("rst_empty", {31'h0, coef_empty}, 32'h1);
    chk("rst_dout", {8'h0, cpu_dout}, 32'h0);
    chk("rst_head", {4'h0, coef_ch, coef_addr, coef_data}, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    rst = 1'b0;
    tick();

    // ch0 fill: interrupt only after the eighth sample, readback of the finished bank
    for (int i = 1; i <= 7; i++) smp(0, 24'(i), 1'b0);
    chk("ch0_int_early", {30'h0, filt_int}, 32'h0);
    smp(0, 24'd8, 1'b0);
    chk("ch0_int", {30'h0, filt_int}, 32'h1);
    for (int i = 0; i < 8; i++) rd($sformatf("ch0_rd%0d", i), 1'b0, 1'b0, 4'(i), 24'(i + 1));
    tick();
    chk("dout_hold", {8'h0, cpu_dout}, 32'h8);

    // ch0 in PEND: ack coinciding with the final sample swaps banks and stays pending
    for (int i = 1; i <= 7; i++) smp(0, 24'(100 + i), 1'b0);
    smp(0, 24'd108, 1'b1);
    chk("sw_int", {30'h0, filt_int}, 32'h1);
    rd("sw_rd0", 1'b0, 1'b0, 4'd0, 24'd101);
    rd("sw_rd7", 1'b0, 1'b0, 4'd7, 24'd108);
    ack(0);
    chk("sw_pend_ack", {30'h0, filt_int}, 32'h0);

    // ch1: two banks without ack reach HOLD, extra samples dropped
    for (int i = 1; i <= 8; i++) smp(1, 24'(i), 1'b0);
    chk("ch1_int", {30'h0, filt_int}, 32'h2);
    for (int i = 9; i <= 21; i++) smp(1, 24'(i), 1'b0);
    rd("hold_rd0", 1'b0, 1'b1, 4'd0, 24'd1);
`ifdef MMU_FILT_OVR_CNT_EN
    rd("ovr_cnt", 1'b1, 1'b1, 4'd8, 24'd5);
`else
    rd("ovr_absent", 1'b1, 1'b1, 4'd8, 24'd0);
`endif
    ack(1);
    chk("hold_ack_int", {30'h0, filt_int}, 32'h2);
    for (int i = 0; i < 8; i++) rd($sformatf("ch1_rd%0d", i), 1'b0, 1'b1, 4'(i), 24'(i + 9));
    rd("ovr_after_ack", 1'b1, 1'b1, 4'd8, 24'd0);
    ack(1);
    chk("ch1_clear", {30'h0, filt_int}, 32'h0);

    // coefficient FIFO: fill, stall, pop-under-stall, in-order drain
    wr("cw0", 1'b1, 1'b0, 4'd0, 24'h0000A0);
    head("hd_first", 1'b0, 3'd0, 24'h0000A0);
    wr("cw1", 1'b1, 1'b1, 4'd3, 24'h0000B3);
    wr("cw2", 1'b1, 1'b0, 4'd7, 24'h0000C7);
    wr("cw3", 1'b1, 1'b1, 4'd5, 24'h0000D5);
    cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = {1'b1, 1'b0, 4'd2}; cpu_din = 24'h0000E2;
    #1;
    chk("stall_full", {31'h0, cpu_stall}, 32'h1);
    coef_rd_en = 1'b1;
    #1;
    chk("stall_pop_same", {31'h0, cpu_stall}, 32'h1);
    tick();
    coef_rd_en = 1'b0;
    #1;
    chk("stall_release", {31'h0, cpu_stall}, 32'h0);
    tick();
    cpu_en = 1'b0;
    head("hd1", 1'b1, 3'd3, 24'h0000B3); pop();
    head("hd2", 1'b0, 3'd7, 24'h0000C7); pop();
    head("hd3", 1'b1, 3'd5, 24'h0000D5); pop();
    head("hd4", 1'b0, 3'd2, 24'h0000E2); pop();
    chk("drained", {31'h0, coef_empty}, 32'h1);
    rd("shadow_b3", 1'b1, 1'b1, 4'd3, 24'h0000B3);
    rd("shadow_e2", 1'b1, 1'b0, 4'd2, 24'h0000E2);
    wr("w_reg0", 1'b0, 1'b0, 4'd1, 24'h123456);
    wr("w_idx8", 1'b1, 1'b0, 4'd8, 24'h654321);
    chk("ignored_no_push", {31'h0, coef_empty}, 32'h1);
    rd("reg0_unchanged", 1'b0, 1'b0, 4'd1, 24'd102);
    pop();
    chk("pop_empty", {31'h0, coef_empty}, 32'h1);
    wr("cw5", 1'b1, 1'b1, 4'd1, 24'h000011);
    head("hd5", 1'b1, 3'd1, 24'h000011);

    // reset mid-fill with an interrupt pending, a FIFO entry queued and nonzero read data
    for (int i = 1; i <= 8; i++) smp(1, 24'(i), 1'b0);
    for (int i = 1; i <= 3; i++) smp(0, 24'(48 + i), 1'b0);
    chk("pre_rst_int", {30'h0, filt_int}, 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_int", {30'h0, filt_int}, 32'h0);
    chk("mid_rst_empty", {31'h0, coef_empty}, 32'h1);
    chk("mid_rst_dout", {8'h0, cpu_dout}, 32'h0);
    chk("mid_rst_head", {4'h0, coef_ch, coef_addr, coef_data}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 1; i <= 7; i++) smp(0, 24'(64 + i), 1'b0);
    chk("post_rst_early", {30'h0, filt_int}, 32'h0);
    smp(0, 24'd72, 1'b0);
    chk("post_rst_int", {30'h0, filt_int}, 32'h1);
    rd("post_rst_rd0", 1'b0, 1'b0, 4'd0, 24'd65);
    rd("post_rst_rd7", 1'b0, 1'b0, 4'd7, 24'd72);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
